// File: rtl/sr_latch_pkg.sv
// Shared definitions for the gated SR latch driver: FSM encoding and
// the legal bounds of the pulse/guard timing parameters.
package sr_latch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    GUARD = 3'd4
  } state_t;

  localparam int CNT_W       = 4;
  localparam int PULSE_W_MIN = 1;
  localparam int PULSE_W_MAX = 15;
  localparam int GAP_W_MIN   = 3;
  localparam int GAP_W_MAX   = 15;

  // Down-counter load value for a phase of w cycles, forced into [lo, hi].
  function automatic logic [CNT_W-1:0] cnt_load(input int w, input int lo, input int hi);
    int v;
    v = (w < lo) ? lo : ((w > hi) ? hi : w);
    return CNT_W'(v - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// Sequences set/clear commands onto a downstream gated SR latch:
// data setup, gate pulse, data hold, then a guard gap with Q feedback check.
module sr_latch_driver
  import sr_latch_pkg::*;
#(
  parameter int PULSE_W        = 4,
  parameter int GAP_W          = 3,
  parameter bit SKIP_REDUNDANT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_op,
  output logic cmd_ready,
  output logic s,
  output logic r,
  output logic g,
  input  logic q_fb,
  input  logic err_clr,
  output logic latch_state,
  output logic known,
  output logic done,
  output logic err
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // SETUP | S/R driven, gate low (data setup)
  // PULSE | gate high for PULSE_W cycles
  // HOLD  | gate low, S/R still driven (data hold)
  // GUARD | S/R/G low for GAP_W cycles, Q feedback checked on the last one

  localparam logic [CNT_W-1:0] PULSE_LD = cnt_load(PULSE_W, PULSE_W_MIN, PULSE_W_MAX);
  localparam logic [CNT_W-1:0] GAP_LD   = cnt_load(GAP_W, GAP_W_MIN, GAP_W_MAX);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_q;
  logic             q_sync;
  logic             cnt_zero;
  logic             redundant;
  logic             err_set;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (q_fb),
    .q     (q_sync)
  );

  // Gated by rst_n so ready is low throughout reset yet high right after release.
  assign cmd_ready = (state == IDLE) && rst_n;
  assign cnt_zero  = (cnt == '0);
  assign redundant = SKIP_REDUNDANT && known && (cmd_op == latch_state);
  assign err_set   = (state == GUARD) && cnt_zero && (q_sync != latch_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= 1'b0;
      s           <= 1'b0;
      r           <= 1'b0;
      g           <= 1'b0;
      latch_state <= 1'b0;
      known       <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (redundant) begin
              done <= 1'b1;
            end else begin
              state <= SETUP;
              op_q  <= cmd_op;
              s     <= cmd_op;
              r     <= ~cmd_op;
            end
          end
        end
        SETUP: begin
          state <= PULSE;
          g     <= 1'b1;
          cnt   <= PULSE_LD;
        end
        PULSE: begin
          if (cnt_zero) begin
            state       <= HOLD;
            g           <= 1'b0;
            latch_state <= op_q;
            known       <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          state <= GUARD;
          s     <= 1'b0;
          r     <= 1'b0;
          cnt   <= GAP_LD;
        end
        GUARD: begin
          if (cnt_zero) begin
            state <= IDLE;
          end else begin
            cnt  <= cnt - 1'b1;
            done <= (cnt == 4'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver: default instance plus a
// PULSE_W=1 instance, each with a behavioural gated SR latch on its outputs.
module tb_sr_latch_driver;

  typedef struct packed {
    logic s;
    logic r;
    logic g;
    logic rdy;
    logic done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_op = 1'b0, err_clr = 1'b0;
  logic cmd_ready, s, r, g, latch_state, known, done, err, q_fb;
  logic lq = 1'b0, q_tie_en = 1'b0, q_tie_val = 1'b0;

  logic cmd_valid2 = 1'b0, cmd_op2 = 1'b0;
  logic cmd_ready2, s2, r2, g2, latch_state2, known2, done2, err2, q_fb2;
  logic lq2 = 1'b0;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  always @(s or r or g) begin
    if (g && s) lq = 1'b1;
    else if (g && r) lq = 1'b0;
  end
  always @(s2 or r2 or g2) begin
    if (g2 && s2) lq2 = 1'b1;
    else if (g2 && r2) lq2 = 1'b0;
  end
  assign q_fb  = q_tie_en ? q_tie_val : lq;
  assign q_fb2 = lq2;

  sr_latch_driver u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .s(s), .r(r), .g(g), .q_fb(q_fb), .err_clr(err_clr),
    .latch_state(latch_state), .known(known), .done(done), .err(err)
  );

  sr_latch_driver #(.PULSE_W(1), .GAP_W(3), .SKIP_REDUNDANT(1'b1)) u_dut_short (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_op(cmd_op2),
    .cmd_ready(cmd_ready2), .s(s2), .r(r2), .g(g2), .q_fb(q_fb2), .err_clr(1'b0),
    .latch_state(latch_state2), .known(known2), .done(done2), .err(err2)
  );

  // Expected outputs in cycle k after an accept edge; k past the command is idle.
  function automatic exp_t trace_at(int k, logic op, int pw, int gw);
    exp_t e;
    e = '0;
    if (k >= 1 && k <= pw + 1) begin
      e.s = op; e.r = !op; e.g = (k >= 2);
    end else if (k == pw + 2) begin
      e.s = op; e.r = !op;
    end else if (k <= pw + gw + 2) begin
      e.done = (k == pw + gw + 2);
    end else begin
      e.rdy = 1'b1;
    end
    return e;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({s, r, g, cmd_ready, done, err, known, latch_state} !== 8'b0)
      $display("FAIL reset_outputs got %b required 00000000",
               {s, r, g, cmd_ready, done, err, known, latch_state});
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_chk++;
    if ({cmd_ready, cmd_ready2} !== 2'b11)
      $display("FAIL reset_release_ready got %b required 11", {cmd_ready, cmd_ready2});
    else n_pass++;
  endtask

  task automatic test_set();
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1;
    for (int k = 1; k <= 9; k++) sbq.push_back(trace_at(k, 1'b1, 4, 3));
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e = sbq.pop_front();
      n_chk++;
      if ({s, r, g, cmd_ready, done} !== e)
        $display("FAIL set_trace k=%0d got srgyd=%b required %b", k, {s, r, g, cmd_ready, done}, e);
      else n_pass++;
    end
    @(negedge clk);
    n_chk++;
    if ({latch_state, known, err, cmd_ready} !== 4'b1101)
      $display("FAIL set_status got lat/known/err/rdy=%b required 1101",
               {latch_state, known, err, cmd_ready});
    else n_pass++;
  endtask

  task automatic test_skip();
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1;
    sbq.push_back(5'b00011);
    sbq.push_back(5'b00010);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      e = sbq.pop_front();
      n_chk++;
      if ({s, r, g, cmd_ready, done} !== e)
        $display("FAIL skip_trace k=%0d got srgyd=%b required %b", k, {s, r, g, cmd_ready, done}, e);
      else n_pass++;
    end
    n_chk++;
    if ({latch_state, known} !== 2'b11)
      $display("FAIL skip_status got lat/known=%b required 11", {latch_state, known});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    apply_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1;
    for (int k = 1; k <= 10; k++) sbq.push_back(trace_at(k, 1'b1, 4, 3));
    for (int k = 1; k <= 9; k++) sbq.push_back(trace_at(k, 1'b0, 4, 3));
    @(posedge clk); #1;
    cmd_op = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      e = sbq.pop_front();
      n_chk++;
      if ({s, r, g, cmd_ready, done} !== e)
        $display("FAIL b2b_trace k=%0d got srgyd=%b required %b", k, {s, r, g, cmd_ready, done}, e);
      else n_pass++;
      n_chk++;
      if (s && r) $display("FAIL b2b_s_and_r k=%0d got s=1 r=1 required not both", k);
      else n_pass++;
      if (k == 15) cmd_valid = 1'b0;
    end
    @(negedge clk);
    n_chk++;
    if ({latch_state, known, err, cmd_ready} !== 4'b0101)
      $display("FAIL b2b_status got lat/known/err/rdy=%b required 0101",
               {latch_state, known, err, cmd_ready});
    else n_pass++;
  endtask

  task automatic test_err();
    exp_t e;
    q_tie_en = 1'b1; q_tie_val = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1;
    for (int k = 1; k <= 9; k++) sbq.push_back(trace_at(k, 1'b1, 4, 3));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e = sbq.pop_front();
      n_chk++;
      if ({s, r, g, cmd_ready, done, err} !== {e, 1'b0})
        $display("FAIL err_trace k=%0d got srgyd_err=%b required %b", k,
                 {s, r, g, cmd_ready, done, err}, {e, 1'b0});
      else n_pass++;
    end
    @(negedge clk);
    n_chk++;
    if (err !== 1'b1) $display("FAIL err_set got %b required 1", err);
    else n_pass++;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_chk++;
    if (err !== 1'b0) $display("FAIL err_clear got %b required 0", err);
    else n_pass++;

    q_tie_val = 1'b1;
    cmd_valid = 1'b1; cmd_op = 1'b0;
    for (int k = 1; k <= 9; k++) sbq.push_back(trace_at(k, 1'b0, 4, 3));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e = sbq.pop_front();
      n_chk++;
      if ({s, r, g, cmd_ready, done} !== e)
        $display("FAIL err2_trace k=%0d got srgyd=%b required %b", k, {s, r, g, cmd_ready, done}, e);
      else n_pass++;
      if (k == 9) err_clr = 1'b1;
    end
    @(negedge clk);
    err_clr = 1'b0;
    n_chk++;
    if (err !== 1'b1) $display("FAIL err_set_wins_clr got %b required 1", err);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (err !== 1'b1) $display("FAIL err_sticky got %b required 1", err);
    else n_pass++;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    q_tie_en = 1'b0;
    n_chk++;
    if (err !== 1'b0) $display("FAIL err_clear2 got %b required 0", err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_pulse();
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1;
    for (int k = 1; k <= 9; k++) sbq.push_back(trace_at(k, 1'b1, 4, 3));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = sbq.pop_front();
      n_chk++;
      if ({s, r, g, cmd_ready, done} !== e)
        $display("FAIL midrst_pre k=%0d got srgyd=%b required %b", k, {s, r, g, cmd_ready, done}, e);
      else n_pass++;
    end
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({s, r, g, known, cmd_ready, latch_state} !== 6'b0)
      $display("FAIL midrst_async got srg/known/rdy/lat=%b required 000000",
               {s, r, g, known, cmd_ready, latch_state});
    else n_pass++;
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1;
    for (int k = 1; k <= 9; k++) sbq.push_back(trace_at(k, 1'b1, 4, 3));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e = sbq.pop_front();
      n_chk++;
      if ({s, r, g, cmd_ready, done} !== e)
        $display("FAIL midrst_post k=%0d got srgyd=%b required %b", k, {s, r, g, cmd_ready, done}, e);
      else n_pass++;
    end
    @(negedge clk);
    n_chk++;
    if ({latch_state, known, err} !== 3'b110)
      $display("FAIL midrst_status got lat/known/err=%b required 110", {latch_state, known, err});
    else n_pass++;
  endtask

  task automatic test_short_pulse();
    exp_t e;
    int ghigh;
    int busy;
    ghigh = 0;
    busy = 0;
    @(negedge clk);
    cmd_valid2 = 1'b1; cmd_op2 = 1'b1;
    for (int k = 1; k <= 7; k++) sbq.push_back(trace_at(k, 1'b1, 1, 3));
    @(posedge clk); #1;
    cmd_valid2 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      e = sbq.pop_front();
      n_chk++;
      if ({s2, r2, g2, cmd_ready2, done2} !== e)
        $display("FAIL short_trace k=%0d got srgyd=%b required %b", k, {s2, r2, g2, cmd_ready2, done2}, e);
      else n_pass++;
      ghigh += int'(g2);
      busy  += int'(!cmd_ready2);
    end
    n_chk++;
    if (ghigh != 1 || busy != 6)
      $display("FAIL short_counts got g_high=%0d busy=%0d required 1 and 6", ghigh, busy);
    else n_pass++;
    n_chk++;
    if ({latch_state2, known2, err2} !== 3'b110)
      $display("FAIL short_status got lat/known/err=%b required 110", {latch_state2, known2, err2});
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_set();
    test_skip();
    test_back_to_back();
    test_err();
    test_reset_mid_pulse();
    test_short_pulse();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 Parameter PULSE_W, default 4, SHALL set gate-high cycles per command (legal 1..15).
REQ-002 Parameter GAP_W, default 3, SHALL set guard cycles after each pulse (legal 3..15).
REQ-003 Parameter SKIP_REDUNDANT, default 1, SHALL suppress pulses that would not change the known latch state.
REQ-004 CLK  in  1  sole clock; all state on rising edge.
REQ-005 RST_N  in  1  reset, asynchronous, active-low.
REQ-006 CMD_VALID  in  1  command present.
REQ-007 CMD_OP  in  1  1 = set latch, 0 = clear latch; sampled on accept.
REQ-008 CMD_READY  out  1  block can accept a command.
REQ-009 S  out  1  set input of the downstream gated SR latch.
REQ-010 R  out  1  reset input of the downstream gated SR latch.
REQ-011 G  out  1  gate/enable input (the latch's CLK pin).
REQ-012 Q_FB  in  1  latch Q output, asynchronous to CLK.
REQ-013 ERR_CLR  in  1  clears ERR.
REQ-014 LATCH_STATE  out  1  last commanded latch value.
REQ-015 KNOWN  out  1  LATCH_STATE is valid.
REQ-016 DONE  out  1  one-cycle pulse on command completion.
REQ-017 ERR  out  1  sticky feedback mismatch flag.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, PULSE, HOLD, GUARD.
REQ-019 CMD_READY SHALL equal 1 only in IDLE; a command is accepted on a rising edge with CMD_VALID=1 and CMD_READY=1.
REQ-020 On accept, if SKIP_REDUNDANT=1, KNOWN=1 and CMD_OP==LATCH_STATE, state SHALL stay IDLE, DONE SHALL pulse the next cycle, S/R/G stay 0.
REQ-021 Otherwise, IDLE->SETUP: drive S=CMD_OP, R=~CMD_OP, G=0 for 1 cycle.
REQ-022 SETUP->PULSE: S/R held, G=1 for exactly PULSE_W cycles.
REQ-023 PULSE->HOLD: G=0, S/R held for 1 cycle (data held past gate fall).
REQ-024 HOLD->GUARD: S=R=G=0 for GAP_W cycles, then GUARD->IDLE with DONE=1 in that last GUARD cycle.
REQ-025 S and R SHALL never both be 1; G SHALL be 1 only in PULSE.
REQ-026 Command cycle count SHALL be 2+PULSE_W+GAP_W; defaults: CMD_READY low 9 cycles after accept.
REQ-027 LATCH_STATE SHALL update to the accepted CMD_OP and KNOWN SHALL set to 1 on entry to HOLD.
REQ-028 Q_FB SHALL pass through a 2-flop synchroniser; on the last GUARD cycle, synchronised Q_FB != LATCH_STATE SHALL set ERR.
REQ-029 ERR SHALL remain 1 until ERR_CLR=1 or reset; a set and ERR_CLR in the same cycle SHALL leave ERR=1.
REQ-030 CMD_VALID/CMD_OP changes outside an accept edge SHALL have no effect.
REQ-031 Pulse and guard counters SHALL be 4 bits, load on state entry, count down, never wrap.

Reset
REQ-032 RST_N=0 SHALL immediately force state IDLE, S=R=G=0, CMD_READY=0 while asserted, DONE=0, ERR=0, KNOWN=0, LATCH_STATE=0, counters and synchroniser=0.
REQ-033 Reset mid-PULSE SHALL drop G asynchronously with S/R; KNOWN=0 afterwards since latch content is indeterminate.
REQ-034 CMD_READY SHALL be 1 in the first cycle after RST_N deasserts.

Structure
REQ-035 The FSM state encoding and the PULSE_W/GAP_W legal bounds SHALL live in a shared package sr_latch_pkg.
REQ-036 The Q_FB synchroniser SHALL be a separate sub-module sync_2ff (async active-low reset, reset value 0).
REQ-037 S, R and G SHALL be driven directly from flops, glitch-free.

Verification
REQ-038 Reset release, CMD_VALID=1 CMD_OP=1, latch model attached -> S=1 cycles 1-6, G=1 cycles 2-5, DONE at cycle 9, LATCH_STATE=1, KNOWN=1, ERR=0.
REQ-039 After set, CMD_OP=1 again (SKIP_REDUNDANT=1) -> no S/R/G activity, DONE next cycle, CMD_READY stays 1.
REQ-040 Set then clear back-to-back with CMD_VALID held -> second accept exactly 10 cycles after first; R pulse mirrors S timing; S&R never both 1.
REQ-041 Q_FB tied 0, set command -> ERR=1 after cycle 9; ERR_CLR pulse -> ERR=0; ERR_CLR and mismatch same cycle -> ERR stays 1.
REQ-042 RST_N asserted during PULSE cycle 3 -> G/S/R drop within same cycle (no edge), KNOWN=0; next set command executes full sequence.
REQ-043 PULSE_W=1, GAP_W=3 -> command length 6 cycles, single G-high cycle.
